// File: rtl/pic_pkg.sv
// ---------------------------------------------------------------------------
// pic_pkg
// Shared definitions for the 8259A CPU-side initiator:
//   - pic_state_t : bus/acknowledge FSM states
//   - ICWx_DEF    : default auto-init command words
//   - pic_a0_t    : A0 encodings for the PIC register groups
//   - max2        : constant helper for sizing the strobe counter
// ---------------------------------------------------------------------------
package pic_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RESP,
        ST_INTA1,
        ST_GAP,
        ST_INTA2,
        ST_VEC
    } pic_state_t;

    // Edge-triggered, single PIC, ICW4 needed / vector base 0x20 / 8086 mode
    localparam logic [7:0] ICW1_DEF = 8'h13;
    localparam logic [7:0] ICW2_DEF = 8'h20;
    localparam logic [7:0] ICW4_DEF = 8'h01;

    // ICW1, OCW2 and OCW3 live at A0=0; ICW2..ICW4 and OCW1 at A0=1
    typedef enum logic {
        A0_ICW1_OCW2_OCW3 = 1'b0,
        A0_ICW2_4_OCW1    = 1'b1
    } pic_a0_t;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pic_strobe_timer.sv
// ---------------------------------------------------------------------------
// pic_strobe_timer
// Loadable down-counter shared by every timed phase (RD/WR strobe, both
// INTA pulses and the inter-pulse gap). Load N-1 when entering a phase;
// o_done is high on the phase's last cycle.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   i_load     : load i_val this cycle
//   i_val      : phase length minus one
//   o_done     : counter is at zero
// ---------------------------------------------------------------------------
module pic_strobe_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_val,
    output logic         o_done
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_load)
            r_cnt <= i_val;
        else if (r_cnt != '0)
            r_cnt <= r_cnt - 1'b1;
    end

    assign o_done = (r_cnt == '0);

endmodule

// File: rtl/pic_cpu_initiator.sv
// ---------------------------------------------------------------------------
// pic_cpu_initiator
// CPU-side master for an 8259A: turns single-byte host commands into timed
// RD/WR bus cycles and answers INT with the two-pulse INTA sequence,
// capturing the vector byte from the second pulse.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   INT, int_enable     : PIC interrupt (async), CPU IF flag
//   INTA, CS, RD, WR    : active-low PIC strobes
//   A0, sys_DataLine    : register address, bidirectional D0-D7
//   cmd_*               : host command handshake and fields
//   rsp_valid/rsp_rdata : one-cycle read response
//   vec_valid/vec       : one-cycle captured interrupt vector
// Build option: PIC_AUTO_INIT_EN issues ICW1, ICW2, ICW4 after reset before
// the host is allowed in and before INT is honoured.
// ---------------------------------------------------------------------------
module pic_cpu_initiator
    import pic_pkg::*;
#(
    parameter int         PULSE_CYCLES = 2,
    parameter int         GAP_CYCLES   = 1,
    parameter logic [7:0] ICW1_VAL     = ICW1_DEF,
    parameter logic [7:0] ICW2_VAL     = ICW2_DEF,
    parameter logic [7:0] ICW4_VAL     = ICW4_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       INT,
    input  logic       int_enable,
    output logic       INTA,
    output logic       CS,
    output logic       RD,
    output logic       WR,
    output logic       A0,
    inout  wire  [7:0] sys_DataLine,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_write,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       vec_valid,
    output logic [7:0] vec
);

    localparam int            CW       = $clog2(max2(PULSE_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CW-1:0] PULSE_LD = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

    pic_state_t    r_state, w_next;
    logic [1:0]    r_int_sync;
    logic          r_write, r_a0;
    logic [7:0]    r_wdata, r_rdata, r_vec;
    logic          w_ready_en, w_pending, w_accept, w_start_init;
    logic          w_done, w_load, w_drive;
    logic [CW-1:0] w_load_val;
    logic [1:0]    w_init_idx;
    logic          w_init_a0;
    logic [7:0]    w_init_data;

    // ---- host gate / auto-init sequencing --------------------------------
`ifdef PIC_AUTO_INIT_EN
    logic [1:0] r_init_idx;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_init_idx <= 2'd0;
        else if (w_start_init)
            r_init_idx <= r_init_idx + 2'd1;
    end

    assign w_init_idx   = r_init_idx;
    assign w_ready_en   = (r_init_idx == 2'd3);
    assign w_start_init = (r_state == ST_IDLE) && !w_ready_en;
`else
    // Holds the host off for exactly the first cycle after reset release
    logic r_rdy_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_rdy_en <= 1'b0;
        else
            r_rdy_en <= 1'b1;
    end

    assign w_init_idx   = 2'd0;
    assign w_ready_en   = r_rdy_en;
    assign w_start_init = 1'b0;
`endif

    always_comb begin
        w_init_a0   = A0_ICW1_OCW2_OCW3;
        w_init_data = ICW1_VAL;
        case (w_init_idx)
            2'd1:    begin w_init_a0 = A0_ICW2_4_OCW1; w_init_data = ICW2_VAL; end
            2'd2:    begin w_init_a0 = A0_ICW2_4_OCW1; w_init_data = ICW4_VAL; end
            default: ;
        endcase
    end

    // ---- interrupt synchronizer and handshake ----------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_int_sync <= 2'b00;
        else
            r_int_sync <= {r_int_sync[0], INT};
    end

    // INT wins over a same-cycle command, so the host sees ready low then
    assign w_pending = r_int_sync[1] & int_enable & w_ready_en;
    assign cmd_ready = (r_state == ST_IDLE) & w_ready_en & ~w_pending;
    assign w_accept  = cmd_valid & cmd_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_write <= 1'b0;
            r_a0    <= 1'b0;
            r_wdata <= 8'h00;
        end else if (w_start_init) begin
            r_write <= 1'b1;
            r_a0    <= w_init_a0;
            r_wdata <= w_init_data;
        end else if (w_accept) begin
            r_write <= cmd_write;
            r_a0    <= cmd_a0;
            r_wdata <= cmd_wdata;
        end
    end

    // ---- FSM -------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_pending) w_next = ST_INTA1;
                       else if (w_accept || w_start_init) w_next = ST_SETUP;
            ST_SETUP:  w_next = ST_STROBE;
            ST_STROBE: if (w_done) w_next = r_write ? ST_HOLD : ST_RESP;
            ST_INTA1:  if (w_done) w_next = ST_GAP;
            ST_GAP:    if (w_done) w_next = ST_INTA2;
            ST_INTA2:  if (w_done) w_next = ST_VEC;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        INTA      = 1'b1;
        CS        = 1'b1;
        RD        = 1'b1;
        WR        = 1'b1;
        A0        = 1'b0;
        w_drive   = 1'b0;
        rsp_valid = 1'b0;
        vec_valid = 1'b0;
        case (r_state)
            ST_SETUP:  begin CS = 1'b0; A0 = r_a0; w_drive = r_write; end
            ST_STROBE: begin
                CS      = 1'b0;
                A0      = r_a0;
                w_drive = r_write;
                WR      = ~r_write;
                RD      = r_write;
            end
            ST_HOLD:   begin CS = 1'b0; A0 = r_a0; w_drive = 1'b1; end
            ST_RESP:   rsp_valid = 1'b1;
            ST_INTA1,
            ST_INTA2:  INTA = 1'b0;
            ST_VEC:    vec_valid = 1'b1;
            default:   ;
        endcase
    end

    // ---- phase timer: reload on entry to any timed phase -----------------
    assign w_load     = (w_next != r_state) &&
                        (w_next inside {ST_STROBE, ST_INTA1, ST_GAP, ST_INTA2});
    assign w_load_val = (w_next == ST_GAP) ? GAP_LD : PULSE_LD;

    pic_strobe_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_load (w_load),
        .i_val  (w_load_val),
        .o_done (w_done)
    );

    // ---- data capture on the last low cycle of RD / second INTA ----------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= 8'h00;
            r_vec   <= 8'h00;
        end else begin
            if (r_state == ST_STROBE && !r_write && w_done)
                r_rdata <= sys_DataLine;
            if (r_state == ST_INTA2 && w_done)
                r_vec <= sys_DataLine;
        end
    end

    assign sys_DataLine = w_drive ? r_wdata : 8'hzz;
    assign rsp_rdata    = r_rdata;
    assign vec          = r_vec;

endmodule

// File: tb/tb_pic_cpu_initiator.sv
// ---------------------------------------------------------------------------
// tb_pic_cpu_initiator
// Randomized bench for pic_cpu_initiator with a small PIC bus model that
// answers RD and INTA. Expected waveforms are built from the bus-cycle
// rules (phase lengths in clocks) rather than from the DUT's internals.
// ---------------------------------------------------------------------------
module tb_pic_cpu_initiator;

    localparam int P = 2;
    localparam int G = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       INT, int_enable;
    logic       INTA, CS, RD, WR, A0;
    wire  [7:0] sys_DataLine;
    logic       cmd_valid, cmd_ready, cmd_write, cmd_a0;
    logic [7:0] cmd_wdata;
    logic       rsp_valid, vec_valid;
    logic [7:0] rsp_rdata, vec;

    int n_total = 0;
    int n_pass  = 0;

    // PIC model: returns rd_byte while RD is low; on INTA it returns a
    // junk byte for the first pulse and the vector on the second.
    logic [7:0] rd_byte, vec_byte, pic_drv;
    logic       vec_phase, pic_en;

    always_comb begin
        pic_en  = 1'b0;
        pic_drv = 8'h00;
        if (!RD) begin
            pic_en  = 1'b1;
            pic_drv = rd_byte;
        end else if (!INTA) begin
            pic_en  = 1'b1;
            pic_drv = vec_phase ? vec_byte : 8'hEE;
        end
    end

    assign sys_DataLine = pic_en ? pic_drv : 8'hzz;

    pic_cpu_initiator #(.PULSE_CYCLES(P), .GAP_CYCLES(G)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .INT          (INT),
        .int_enable   (int_enable),
        .INTA         (INTA),
        .CS           (CS),
        .RD           (RD),
        .WR           (WR),
        .A0           (A0),
        .sys_DataLine (sys_DataLine),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_a0       (cmd_a0),
        .cmd_wdata    (cmd_wdata),
        .rsp_valid    (rsp_valid),
        .rsp_rdata    (rsp_rdata),
        .vec_valid    (vec_valid),
        .vec          (vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Called at a negedge with rst_n low; releases reset and waits for ready.
    task automatic post_reset();
`ifdef PIC_AUTO_INIT_EN
        logic [8:0] init_exp [3] = '{{1'b0, 8'h13}, {1'b1, 8'h20}, {1'b1, 8'h01}};
        int t;
`endif
        rst_n = 1'b1;
        #1 chk("rdy_first", cmd_ready, 1'b0);
`ifdef PIC_AUTO_INIT_EN
        for (int i = 0; i < 3; i++) begin
            t = 0;
            while (WR !== 1'b0 && t < 20) begin @(negedge clk); t++; end
            chk("init_wr", {CS, A0, sys_DataLine}, {1'b0, init_exp[i]});
            t = 0;
            while (WR === 1'b0 && t < 20) begin @(negedge clk); t++; end
        end
        t = 0;
        while (cmd_ready !== 1'b1 && t < 20) begin @(negedge clk); t++; end
        chk("init_rdy", cmd_ready, 1'b1);
`else
        @(negedge clk);
        chk("rdy_second", cmd_ready, 1'b1);
`endif
    endtask

    // Starts at an IDLE negedge; returns at the IDLE negedge after the cycle.
    task automatic do_cmd(input logic w, input logic a, input logic [7:0] d, input logic [7:0] rb);
        logic ecs, ewr, erd, erv;
        cmd_write = w; cmd_a0 = a; cmd_wdata = d; rd_byte = rb; cmd_valid = 1'b1;
        chk("accept_rdy", cmd_ready, 1'b1);
        for (int k = 1; k <= P + 3; k++) begin
            @(negedge clk);
            cmd_valid = 1'b0;
            ecs = !(k <= (w ? P + 2 : P + 1));
            ewr = !(w && k >= 2 && k <= P + 1);
            erd = !(!w && k >= 2 && k <= P + 1);
            erv = (!w && k == P + 2);
            chk(w ? "wr_pins" : "rd_pins",
                {INTA, CS, RD, WR, (CS ? 1'b0 : A0), rsp_valid},
                {1'b1, ecs, erd, ewr, (ecs ? 1'b0 : a), erv});
            if (w && !ecs) chk("wr_data", sys_DataLine, d);
            if (erv)       chk("rd_data", rsp_rdata, rb);
        end
        chk("ready_after", cmd_ready, 1'b1);
    endtask

    // Caller has just created the pending condition; INTA falls 'lead'
    // clocks later. Returns at the IDLE negedge after vec_valid.
    task automatic do_int(input logic [7:0] vb, input int lead);
        logic el, ev;
        vec_phase = 1'b0;
        vec_byte  = vb;
        for (int j = 1; j <= lead + 2 * P + G + 1; j++) begin
            @(negedge clk);
            if (j == lead)     INT = 1'b0;
            if (j == lead + P) vec_phase = 1'b1;
            el = (j >= lead && j < lead + P) || (j >= lead + P + G && j < lead + 2 * P + G);
            ev = (j == lead + 2 * P + G);
            chk("ack_pins", {INTA, CS, RD, WR, vec_valid}, {!el, 1'b1, 1'b1, 1'b1, ev});
            if (ev) chk("vec", vec, vb);
        end
        chk("ack_ready", cmd_ready, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lows;
        rst_n = 1'b0; INT = 1'b0; int_enable = 1'b1;
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_a0 = 1'b0; cmd_wdata = 8'h00;
        rd_byte = 8'h00; vec_byte = 8'h00; vec_phase = 1'b0;

        repeat (3) @(negedge clk);
        chk("rst_pins", {INTA, CS, RD, WR, A0}, 5'b11110);
        chk("rst_valids", {rsp_valid, vec_valid, cmd_ready}, 3'b000);
        chk("rst_data", {rsp_rdata, vec}, 16'h0000);
        post_reset();

        // directed: write then back-to-back read (read also shows bus released)
        do_cmd(1'b1, 1'b1, 8'hFB, 8'h00);
        do_cmd(1'b0, 1'b0, 8'h00, 8'h04);

        // directed: INT acknowledge
        INT = 1'b1;
        do_int(8'h21, 3);

        // INT and command in the same IDLE cycle: INTA first
        INT = 1'b1;
        @(negedge clk);
        @(negedge clk);
        cmd_write = 1'b1; cmd_a0 = 1'b1; cmd_wdata = 8'h55; cmd_valid = 1'b1;
        chk("prio_ready", cmd_ready, 1'b0);
        do_int(8'h27, 1);
        do_cmd(1'b1, 1'b1, 8'h55, 8'h00);

        // int_enable gating
        int_enable = 1'b0; INT = 1'b1;
        lows = 0;
        repeat (6) begin @(negedge clk); if (!INTA) lows++; end
        chk("masked_inta", lows, 0);
        int_enable = 1'b1;
        do_int(8'h2A, 1);

        // randomized mix
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: do_cmd(1'b1, 1'($urandom), 8'($urandom), 8'h00);
                1: do_cmd(1'b0, 1'($urandom), 8'h00, 8'($urandom));
                default: begin INT = 1'b1; do_int(8'($urandom), 3); end
            endcase
        end

        // reset asserted in the middle of a WR pulse
        cmd_write = 1'b1; cmd_a0 = 1'b0; cmd_wdata = 8'hAA; cmd_valid = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_wr_low", WR, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("mid_rst_pins", {INTA, CS, RD, WR}, 4'hF);
        @(negedge clk);
        post_reset();
        do_cmd(1'b0, 1'b1, 8'h00, 8'h3C);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
